cw_envelope_shaper: RTL and testbench
=====================================

# cw_envelope_shaper

Downstream of the iambic/straight keyer: converts the keyer's hard `KeyOn` into a raised-cosine amplitude envelope for the TX CW carrier, removing key clicks. Ramps are walked through a 64-entry shaping table, one step per programmable number of sample strobes. A mid-ramp key change reverses direction from the current point rather than jumping. `busy` covers the ramp-down tail so the PTT/relay logic can hold TX until the envelope is fully zero.

## Interface
- `TBL_DEPTH`, 64: shaping-table entries; index width 6.
- `ENV_W`, 16: envelope width, unsigned.
- `clk`  in  1  IF clock (48 MHz domain), single clock for the whole block.
- `rstb`  in  1  synchronous, active-low reset.
- `key_on`  in  1  keyer `KeyOn` (active high), already synchronous to `clk`.
- `tx_en`  in  1  keyer `TxEN`; low forces abort.
- `samp_stb`  in  1  one-cycle TX sample strobe (nominal 48 kHz).
- `ramp_div`  in  8  strobes per table step minus 1 (0 = step every strobe).
- `env`  out  ENV_W  envelope amplitude; 0 = silent, 16'hFFFF = full.
- `busy`  out  1  high whenever `env` is non-zero or a ramp is in progress.
- `ramp_done`  out  1  one-cycle pulse when ramp-down reaches index 0 normally.
- `abort`  out  1  one-cycle pulse when `tx_en` falls while not IDLE.

## Operation
- States: IDLE, UP, HOLD, DOWN.
- `idx` (6 b) addresses the table. table[0] = 0, table[63] = 16'hFFFF, monotonic non-decreasing, raised-cosine shape: 0.5·(1−cos(π·i/63)) scaled to 65535, rounded.
- Prescaler `pcnt` (8 b): on `samp_stb`, if `pcnt == ramp_div` → step event, `pcnt` ← 0; else `pcnt` + 1. `pcnt` is cleared on entry to IDLE and in HOLD.
- Transitions:
  - IDLE: `key_on & tx_en` → UP with `idx` = 0.
  - UP: step → `idx` + 1; at `idx` = 63 → HOLD. `key_on` low → DOWN with `idx` unchanged.
  - HOLD: `key_on` low → DOWN.
  - DOWN: step → `idx` − 1; stepping from `idx` = 0 → IDLE and pulse `ramp_done`. `key_on` high → UP with `idx` unchanged.
- Abort: `tx_en` low in any non-IDLE state → IDLE, `idx` ← 0, `env` ← 0 on the next cycle, one `abort` pulse. Abort has priority over every other transition.
- A `key_on` change and a step event in the same cycle: the direction change wins and `idx` does not move that cycle.
- `ramp_div` is sampled live. A change mid-ramp takes effect at the next compare. If the new value is below the current `pcnt`, the counter runs until it wraps at 255 and then matches.
- `busy` = (state != IDLE).

## Timing
- Reset (`rstb` low at a `clk` edge): state IDLE, `idx` 0, `pcnt` 0, `env` 0, `busy` 0, `ramp_done` 0, `abort` 0. Reset mid-ramp behaves exactly like abort, but with no `abort` pulse.
- `env` is registered: it equals table[`idx`] one clock after `idx` updates (ROM read latency 1).
- Full ramp duration = 64·(`ramp_div`+1) strobes. Example: `ramp_div` = 3 at 48 kHz gives 5.33 ms.
- `busy` rises the cycle after `key_on & tx_en` is seen in IDLE. It falls together with the `ramp_done` pulse. `env` reaches 0 one cycle earlier than that, or on the same cycle as the abort.
- Exactly one step per step event; no step without `samp_stb`.

## Structure
- Package `cw_env_pkg`:
  - state enum {IDLE, UP, HOLD, DOWN};
  - `CW_ENV_TBL_DEPTH` = 64, `CW_ENV_W` = 16, `CW_ENV_IDX_MAX` = 63.
- Sub-module `cw_env_rom`: 64×16 synchronous ROM holding the raised-cosine table. Inputs `clk`, `addr[5:0]`; output `q[15:0]`; 1-cycle latency. Generated from a .mif/.hex file.
- Top contains the FSM, prescaler and pulse outputs.

## Test plan
- Basic keying: `ramp_div` = 0, strobe every 10 clk. Raise `key_on` & `tx_en` → `env` climbs through 64 table values to 16'hFFFF after 64 strobes, holds there. Drop `key_on` → mirror descent to 0, then a single `ramp_done` pulse and `busy` low.
- Divider: `ramp_div` = 3 → `idx` advances every 4th strobe; HOLD is entered after exactly 256 strobes.
- Reversal: release `key_on` at `idx` = 20 in UP → `env` descends from table[20] with no discontinuity. Re-key at `idx` = 10 in DOWN → climbs again from 10; no `ramp_done` pulse.
- Abort: drop `tx_en` in HOLD → `env` = 0 on the next cycle, one `abort` pulse, state IDLE, no `ramp_done`.
- Simultaneous events: `key_on` falls in the same cycle as a step in UP at `idx` = 40 → state DOWN, `idx` stays 40. Keying with `tx_en` low in IDLE → no response.
- Reset mid-DOWN at `idx` = 30 → next cycle all outputs 0, state IDLE, no pulses.

Source files
------------

// File: rtl/cw_env_pkg.sv
// Shared types and constants for the CW envelope shaper.
package cw_env_pkg;

  localparam int unsigned CW_ENV_TBL_DEPTH = 64;
  localparam int unsigned CW_ENV_W         = 16;
  localparam int unsigned CW_ENV_IDX_MAX   = 63;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    HOLD = 2'd2,
    DOWN = 2'd3
  } cw_env_state_e;

endpackage

// File: rtl/cw_env_rom.sv
// 64x16 synchronous ROM: round(65535 * 0.5 * (1 - cos(pi * i / 63))), one-cycle read latency.
module cw_env_rom
  import cw_env_pkg::*;
(
  input  logic                clk,
  input  logic [5:0]          addr,
  output logic [CW_ENV_W-1:0] q
);

  localparam logic [CW_ENV_W-1:0] Tbl [CW_ENV_TBL_DEPTH] = '{
    16'd0,     16'd41,    16'd163,   16'd366,   16'd650,   16'd1013,  16'd1456,  16'd1976,
    16'd2573,  16'd3245,  16'd3990,  16'd4807,  16'd5694,  16'd6647,  16'd7666,  16'd8747,
    16'd9888,  16'd11086, 16'd12337, 16'd13640, 16'd14990, 16'd16384, 16'd17819, 16'd19291,
    16'd20796, 16'd22331, 16'd23893, 16'd25476, 16'd27077, 16'd28693, 16'd30319, 16'd31951,
    16'd33584, 16'd35216, 16'd36842, 16'd38458, 16'd40059, 16'd41642, 16'd43204, 16'd44739,
    16'd46244, 16'd47716, 16'd49151, 16'd50545, 16'd51895, 16'd53198, 16'd54449, 16'd55647,
    16'd56788, 16'd57869, 16'd58888, 16'd59841, 16'd60728, 16'd61545, 16'd62290, 16'd62962,
    16'd63559, 16'd64079, 16'd64522, 16'd64885, 16'd65169, 16'd65372, 16'd65494, 16'd65535
  };

  always_ff @(posedge clk) begin
    q <= Tbl[addr];
  end

endmodule

// File: rtl/cw_envelope_shaper.sv
// Turns the keyer's hard KeyOn into a raised-cosine TX envelope; ramps reverse in place on key change.
module cw_envelope_shaper
  import cw_env_pkg::*;
#(
  parameter int unsigned TBL_DEPTH = CW_ENV_TBL_DEPTH,
  parameter int unsigned ENV_W     = CW_ENV_W
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             key_on,
  input  logic             tx_en,
  input  logic             samp_stb,
  input  logic [7:0]       ramp_div,
  output logic [ENV_W-1:0] env,
  output logic             busy,
  output logic             ramp_done,
  output logic             abort
);

  localparam int unsigned     IdxW   = $clog2(TBL_DEPTH);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(TBL_DEPTH - 1);
  localparam logic [IdxW-1:0] IdxOne = IdxW'(1);

  cw_env_state_e    state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [7:0]       pcnt_q, pcnt_d;
  logic             ramp_done_q, ramp_done_d;
  logic             abort_q, abort_d;
  logic             step;
  logic [ENV_W-1:0] rom_q;

  assign step = samp_stb && (pcnt_q == ramp_div);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pcnt_d      = pcnt_q;
    ramp_done_d = 1'b0;
    abort_d     = 1'b0;
    if (samp_stb) begin
      pcnt_d = step ? 8'd0 : pcnt_q + 8'd1;
    end
    if ((state_q != IDLE) && !tx_en) begin
      state_d = IDLE;
      idx_d   = '0;
      pcnt_d  = 8'd0;
      abort_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          pcnt_d = 8'd0;
          if (key_on && tx_en) begin
            state_d = UP;
            idx_d   = '0;
          end
        end
        // A direction change takes precedence over a coincident step.
        UP: begin
          if (!key_on) begin
            state_d = DOWN;
          end else if (step) begin
            if (idx_q == IdxMax) state_d = HOLD;
            else                 idx_d   = idx_q + IdxOne;
          end
        end
        HOLD: begin
          pcnt_d = 8'd0;
          if (!key_on) state_d = DOWN;
        end
        DOWN: begin
          if (key_on) begin
            state_d = UP;
          end else if (step) begin
            if (idx_q == '0) begin
              state_d     = IDLE;
              pcnt_d      = 8'd0;
              ramp_done_d = 1'b1;
            end else begin
              idx_d = idx_q - IdxOne;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pcnt_q      <= 8'd0;
      ramp_done_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pcnt_q      <= pcnt_d;
      ramp_done_q <= ramp_done_d;
      abort_q     <= abort_d;
    end
  end

  cw_env_rom u_rom (
    .clk  (clk),
    .addr (idx_q),
    .q    (rom_q)
  );

  // ROM has no reset; gating by state zeroes env at reset and on the abort cycle.
  assign busy      = (state_q != IDLE);
  assign env       = busy ? rom_q : '0;
  assign ramp_done = ramp_done_q;
  assign abort     = abort_q;

endmodule

// File: tb/tb_cw_envelope_shaper.sv
// Directed bench for cw_envelope_shaper with an env scoreboard and a cosine reference table.
module tb_cw_envelope_shaper;
  import cw_env_pkg::*;

  logic        clk = 1'b0;
  logic        rstb;
  logic        key_on;
  logic        tx_en;
  logic        samp_stb;
  logic [7:0]  ramp_div;
  logic [15:0] env;
  logic        busy;
  logic        ramp_done;
  logic        abort;

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;
  int ab_cnt = 0;
  int tbl [64];
  logic [15:0] exp_q [$];

  cw_envelope_shaper dut (
    .clk       (clk),
    .rstb      (rstb),
    .key_on    (key_on),
    .tx_en     (tx_en),
    .samp_stb  (samp_stb),
    .ramp_div  (ramp_div),
    .env       (env),
    .busy      (busy),
    .ramp_done (ramp_done),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ramp_done === 1'b1) rd_cnt++;
    if (abort === 1'b1)     ab_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic strobe(input int gap);
    samp_stb = 1'b1;
    tick();
    samp_stb = 1'b0;
    repeat (gap - 1) tick();
  endtask

  // Push the expected envelope, strobe, then pop and compare once the ROM has caught up.
  task automatic stb_chk(input string tag, input int expv);
    exp_q.push_back(16'(expv));
    strobe(10);
    if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    else                   chk(tag, 32'(env), 32'(exp_q.pop_front()));
  endtask

  task automatic chk_state(input string tag, input cw_env_state_e st, input int idx);
    chk({tag, "_state"}, 32'(dut.state_q), 32'(st));
    chk({tag, "_idx"}, 32'(dut.idx_q), 32'(idx));
  endtask

  initial begin
    int rd0;
    int ab0;
    for (int i = 0; i < 64; i++) begin
      real v;
      v = 32767.5 * (1.0 - $cos(3.14159265358979 * i / 63.0));
      tbl[i] = $rtoi(v + 0.5);
    end

    rstb = 1'b0; key_on = 1'b0; tx_en = 1'b0; samp_stb = 1'b0; ramp_div = 8'd0;
    repeat (3) tick();
    chk("rst_env", 32'(env), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(ramp_done), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk_state("rst", IDLE, 0);
    rstb = 1'b1;

    // Keying without tx_en must be ignored.
    key_on = 1'b1;
    repeat (3) strobe(4);
    chk("noten_busy", 32'(busy), 32'd0);
    chk("noten_env", 32'(env), 32'd0);
    key_on = 1'b0;
    tick();

    // Basic keying, step every strobe.
    tx_en = 1'b1;
    key_on = 1'b1;
    tick();
    chk("up_busy", 32'(busy), 32'd1);
    chk_state("up_entry", UP, 0);
    tick();
    chk("up_env0", 32'(env), 32'd0);
    for (int k = 1; k <= 63; k++) stb_chk("up_env", tbl[k]);
    stb_chk("up_env64", 16'hFFFF);
    chk_state("hold64", HOLD, 63);
    for (int k = 0; k < 5; k++) stb_chk("hold_env", 16'hFFFF);
    key_on = 1'b0;
    tick();
    chk_state("down_entry", DOWN, 63);
    for (int k = 1; k <= 63; k++) stb_chk("down_env", tbl[63 - k]);
    chk("down_busy_tail", 32'(busy), 32'd1);
    chk("down_done_none", 32'(rd_cnt), 32'd0);
    samp_stb = 1'b1;
    tick();
    samp_stb = 1'b0;
    chk("end_done", 32'(ramp_done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_env", 32'(env), 32'd0);
    repeat (3) tick();
    chk("end_done_cnt", 32'(rd_cnt), 32'd1);

    // Divider: idx advances every 4th strobe, HOLD after 256 strobes.
    ramp_div = 8'd3;
    key_on = 1'b1;
    tick();
    for (int s = 1; s <= 256; s++) begin
      strobe(2);
      if (s == 3)   chk_state("div_s3", UP, 0);
      if (s == 4)   chk_state("div_s4", UP, 1);
      if (s == 255) chk_state("div_s255", UP, 63);
      if (s == 256) chk_state("div_s256", HOLD, 63);
    end

    // Abort in HOLD.
    rd0 = rd_cnt;
    ab0 = ab_cnt;
    tx_en = 1'b0;
    tick();
    chk("abort_pulse", 32'(abort), 32'd1);
    chk("abort_env", 32'(env), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk_state("abort", IDLE, 0);
    tick();
    chk("abort_pulse_end", 32'(abort), 32'd0);
    repeat (2) tick();
    chk("abort_cnt", 32'(ab_cnt), 32'(ab0 + 1));
    chk("abort_no_done", 32'(rd_cnt), 32'(rd0));

    // Reversal at idx 20 and again at idx 10.
    ramp_div = 8'd0;
    key_on = 1'b0;
    tx_en = 1'b1;
    tick();
    key_on = 1'b1;
    tick();
    for (int k = 1; k <= 20; k++) stb_chk("rev_up", tbl[k]);
    key_on = 1'b0;
    tick();
    chk_state("rev_down", DOWN, 20);
    chk("rev_env20", 32'(env), 32'(tbl[20]));
    for (int k = 19; k >= 10; k--) stb_chk("rev_down_env", tbl[k]);
    key_on = 1'b1;
    tick();
    chk_state("rev_up2", UP, 10);
    for (int k = 11; k <= 40; k++) stb_chk("rev_up2_env", tbl[k]);
    chk("rev_no_done", 32'(rd_cnt), 32'(rd0));

    // Key release coincident with a step at idx 40.
    key_on = 1'b0;
    samp_stb = 1'b1;
    tick();
    samp_stb = 1'b0;
    chk_state("simul", DOWN, 40);
    tick();
    chk("simul_env", 32'(env), 32'(tbl[40]));
    for (int k = 39; k >= 30; k--) stb_chk("pre_rst_env", tbl[k]);

    // Reset mid-DOWN at idx 30.
    ab0 = ab_cnt;
    rstb = 1'b0;
    tick();
    chk("mrst_env", 32'(env), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(ramp_done), 32'd0);
    chk("mrst_abort", 32'(abort), 32'd0);
    chk_state("mrst", IDLE, 0);
    rstb = 1'b1;
    repeat (3) tick();
    chk("mrst_abort_cnt", 32'(ab_cnt), 32'(ab0));
    chk("mrst_done_cnt", 32'(rd_cnt), 32'(rd0));
    chk("mrst_idle_env", 32'(env), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
